// File: rtl/profiler_frame_tx_pkg.sv
// rtl/profiler_frame_tx_pkg.sv - shared types and constants for the profiler frame transmitter
// Purpose: transmit FSM state encoding, default frame sync bytes, frame length helper.
// Ports: none (package).
package profiler_frame_tx_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC0,
    S_SYNC1,
    S_SEQ,
    S_COUNT,
    S_PAYLOAD,
    S_CHK
  } tx_state_t;

  localparam logic [7:0] DEF_SYNC0 = 8'hA5;
  localparam logic [7:0] DEF_SYNC1 = 8'h5A;

  // Bytes on the wire for one frame: two sync, seq, count, payload, checksum.
  function automatic int frame_len(input int n, input int cw);
    return 5 + n * cw / 8;
  endfunction

endpackage

// File: rtl/profiler_frame_tx_if.sv
// rtl/profiler_frame_tx_if.sv - valid/ready byte stream carrying profiler frames
// Purpose: groups the outgoing byte handshake.
// Ports: tx_data (byte), tx_valid (byte valid), tx_ready (sink accepts).
//   master: frame source; slave: byte sink (e.g. UART transmitter).
interface profiler_frame_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/profiler_frame_tx.sv
// rtl/profiler_frame_tx.sv - captures a counter snapshot bank and serialises it as a framed byte stream
// Purpose: on a snapshot pulse latch the whole counter bank and send
//   SYNC0 SYNC1 SEQ N counter0..counterN-1 (little-endian) CHK, CHK = XOR of SEQ..last payload byte.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   enable             low: no new frames; statistics cleared once idle
//   snapshot_valid     one-cycle pulse, counters_in holds a fresh snapshot
//   counters_in        counter i at [i*COUNTER_WIDTH +: COUNTER_WIDTH]
//   tx                 outgoing byte stream (master side)
//   busy               frame in flight (latch until checksum accepted)
//   frame_count        frames fully sent, wraps
//   dropped_snapshots  snapshots ignored while busy, saturates
module profiler_frame_tx
  import profiler_frame_tx_pkg::*;
#(
  parameter int         NUM_COUNTERS  = 8,
  parameter int         COUNTER_WIDTH = 32,
  parameter logic [7:0] SYNC0         = DEF_SYNC0,
  parameter logic [7:0] SYNC1         = DEF_SYNC1
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  enable,
  input  logic                                  snapshot_valid,
  input  logic [NUM_COUNTERS*COUNTER_WIDTH-1:0] counters_in,
  profiler_frame_tx_if.master                   tx,
  output logic                                  busy,
  output logic [15:0]                           frame_count,
  output logic [15:0]                           dropped_snapshots
);

  localparam int BANK_W = NUM_COUNTERS * COUNTER_WIDTH;
  localparam int NBYTES = BANK_W / 8;
  localparam int BIW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [BIW-1:0] LAST_IDX   = BIW'(NBYTES - 1);
  localparam logic [7:0]     COUNT_BYTE = 8'(NUM_COUNTERS);

  tx_state_t          state_q, state_d;
  logic [BANK_W-1:0]  bank_q, bank_d;
  logic [BIW-1:0]     idx_q, idx_d;
  logic [7:0]         seq_q, seq_d;
  logic [7:0]         chk_q, chk_d;
  logic [15:0]        frame_count_q, frame_count_d;
  logic [15:0]        dropped_q, dropped_d;

  logic               accept;
  logic [7:0]         cur_byte;
  logic [BIW+2:0]     bit_sel;

  assign tx.tx_valid       = (state_q != S_IDLE);
  assign tx.tx_data        = cur_byte;
  assign busy              = (state_q != S_IDLE);
  assign frame_count       = frame_count_q;
  assign dropped_snapshots = dropped_q;
  assign accept            = tx.tx_valid & tx.tx_ready;

  // Byte presented in the current state; zero while idle.
  always_comb begin
    bit_sel  = {idx_q, 3'b000};
    cur_byte = 8'h00;
    case (state_q)
      S_SYNC0:   cur_byte = SYNC0;
      S_SYNC1:   cur_byte = SYNC1;
      S_SEQ:     cur_byte = seq_q;
      S_COUNT:   cur_byte = COUNT_BYTE;
      S_PAYLOAD: cur_byte = bank_q[bit_sel +: 8];
      S_CHK:     cur_byte = chk_q;
      default:   cur_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    bank_d        = bank_q;
    idx_d         = idx_q;
    seq_d         = seq_q;
    chk_d         = chk_q;
    frame_count_d = frame_count_q;
    dropped_d     = dropped_q;

    case (state_q)
      S_IDLE: begin
        if (enable && snapshot_valid) begin
          bank_d  = counters_in;
          state_d = S_SYNC0;
        end else if (!enable) begin
          frame_count_d = 16'h0000;
          dropped_d     = 16'h0000;
          seq_d         = 8'h00;
        end
      end
      S_SYNC0: if (accept) state_d = S_SYNC1;
      S_SYNC1: if (accept) state_d = S_SEQ;
      S_SEQ: if (accept) begin
        chk_d   = chk_q ^ seq_q;
        state_d = S_COUNT;
      end
      S_COUNT: if (accept) begin
        chk_d   = chk_q ^ COUNT_BYTE;
        idx_d   = '0;
        state_d = S_PAYLOAD;
      end
      S_PAYLOAD: if (accept) begin
        chk_d = chk_q ^ cur_byte;
        if (idx_q == LAST_IDX) state_d = S_CHK;
        else                   idx_d   = idx_q + BIW'(1);
      end
      S_CHK: if (accept) begin
        frame_count_d = frame_count_q + 16'd1;
        seq_d         = seq_q + 8'd1;
        chk_d         = 8'h00;
        state_d       = S_IDLE;
        // A snapshot arriving as the checksum leaves starts the next frame directly.
        if (enable && snapshot_valid) begin
          bank_d  = counters_in;
          state_d = S_SYNC0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if ((state_q != S_IDLE) && enable && snapshot_valid &&
        !((state_q == S_CHK) && accept) && (dropped_q != 16'hFFFF))
      dropped_d = dropped_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      bank_q        <= '0;
      idx_q         <= '0;
      seq_q         <= 8'h00;
      chk_q         <= 8'h00;
      frame_count_q <= 16'h0000;
      dropped_q     <= 16'h0000;
    end else begin
      state_q       <= state_d;
      bank_q        <= bank_d;
      idx_q         <= idx_d;
      seq_q         <= seq_d;
      chk_q         <= chk_d;
      frame_count_q <= frame_count_d;
      dropped_q     <= dropped_d;
    end
  end

endmodule

// File: tb/tb_profiler_frame_tx.sv
// tb/tb_profiler_frame_tx.sv - self-checking bench for profiler_frame_tx
module tb_profiler_frame_tx;
  import profiler_frame_tx_pkg::*;

  localparam int NC = 8;
  localparam int CW = 32;
  localparam int BW = NC * CW;
  localparam int FL = frame_len(NC, CW);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic          snapshot_valid;
  logic [BW-1:0] counters_in;
  logic          busy;
  logic [15:0]   frame_count;
  logic [15:0]   dropped_snapshots;

  profiler_frame_tx_if bus ();

  profiler_frame_tx #(.NUM_COUNTERS(NC), .COUNTER_WIDTH(CW)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .enable            (enable),
    .snapshot_valid    (snapshot_valid),
    .counters_in       (counters_in),
    .tx                (bus.master),
    .busy              (busy),
    .frame_count       (frame_count),
    .dropped_snapshots (dropped_snapshots)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [BW-1:0] bank;
    logic [7:0]    seq;
    logic [7:0]    chk;
    bit            stall;
    int            n_mid;
    bit            pulse_chk;
    int            en_low;
    bit            chained;
    logic [15:0]   exp_drop;
  } row_t;

  row_t rows [7];

  // Called at posedge+1 while idle; latch happens on the next posedge.
  task automatic start_frame(input logic [BW-1:0] bank);
    snapshot_valid = 1'b1;
    counters_in    = bank;
    @(posedge clk); #1;
    snapshot_valid = 1'b0;
    counters_in    = ~bank;
  endtask

  task automatic run_frame(input string tag, input logic [BW-1:0] bank, input logic [7:0] seq,
                           input logic [7:0] chkb, input bit stall, input int n_mid,
                           input bit pulse_chk, input logic [BW-1:0] next_bank,
                           input int en_low, output int busy_cycles);
    logic [7:0] exp [FL];
    int         n = 0;
    int         cyc = 0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    exp[0] = 8'hA5;
    exp[1] = 8'h5A;
    exp[2] = seq;
    exp[3] = 8'(NC);
    for (int k = 0; k < BW / 8; k++) exp[4 + k] = bank[k*8 +: 8];
    exp[FL-1] = chkb;
    busy_cycles = 0;
    while (n < FL && cyc < 400) begin
      bus.tx_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (en_low >= 0 && cyc >= en_low) enable = 1'b0;
      if (n_mid > 0 && cyc > 0 && cyc % 3 == 0 && cyc / 3 <= n_mid) begin
        snapshot_valid = 1'b1;
        counters_in    = {8{$urandom}};
      end
      if (pulse_chk && n == FL - 1 && bus.tx_ready) begin
        snapshot_valid = 1'b1;
        counters_in    = next_bank;
      end
      @(negedge clk);
      if (busy) busy_cycles++;
      if (prev_stall) begin
        checks++;
        if (!(bus.tx_valid === 1'b1 && bus.tx_data === prev_data)) begin
          errors++;
          $display("FAIL %s_stall_hold actual=%b/%h required=1/%h", tag, bus.tx_valid, bus.tx_data, prev_data);
        end
      end
      if (n > 0) check($sformatf("%s_no_bubble", tag), 32'(bus.tx_valid), 32'd1);
      if (bus.tx_valid === 1'b1 && bus.tx_ready === 1'b1) begin
        check($sformatf("%s_byte%0d", tag, n), 32'(bus.tx_data), 32'(exp[n]));
        n++;
      end
      prev_stall = (bus.tx_valid === 1'b1) && !bus.tx_ready;
      prev_data  = bus.tx_data;
      @(posedge clk); #1;
      snapshot_valid = 1'b0;
      counters_in    = ~bank;
      cyc++;
    end
    check($sformatf("%s_bytes_seen", tag), 32'(n), 32'(FL));
    bus.tx_ready = 1'b1;
  endtask

  int             bc;
  logic [BW-1:0]  b;
  logic [BW-1:0]  nb;

  initial begin
    rst_n          = 1'b0;
    enable         = 1'b1;
    snapshot_valid = 1'b0;
    counters_in    = '0;
    bus.tx_ready   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    check("rst_tx_data", 32'(bus.tx_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_count", 32'(frame_count), 32'd0);
    check("rst_dropped", 32'(dropped_snapshots), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    b = '0;                                                       rows[0] = '{b, 8'h00, 8'h08, 1'b0, 0, 1'b0, -1, 1'b0, 16'd0};
    b = '0; b[0 +: 32] = 32'h11223344;                            rows[1] = '{b, 8'h01, 8'h4D, 1'b0, 0, 1'b0, -1, 1'b0, 16'd0};
    b = '0; b[0 +: 32] = 32'h11223344;                            rows[2] = '{b, 8'h02, 8'h4E, 1'b1, 0, 1'b0, -1, 1'b0, 16'd0};
    b = '0; b[96 +: 32] = 32'h01020304; b[224 +: 32] = 32'hFFFFFFFF; rows[3] = '{b, 8'h03, 8'h0F, 1'b1, 0, 1'b0, -1, 1'b0, 16'd0};
    b = '0; b[32 +: 32] = 32'hDEADBEEF;                           rows[4] = '{b, 8'h04, 8'h2E, 1'b0, 3, 1'b1, -1, 1'b0, 16'd3};
    b = '0; b[0 +: 32] = 32'h00000001; b[224 +: 32] = 32'h80000000; rows[5] = '{b, 8'h05, 8'h8C, 1'b0, 0, 1'b0, -1, 1'b1, 16'd3};
    b = '0; b[64 +: 32] = 32'hA5A5A5A5;                           rows[6] = '{b, 8'h06, 8'h0E, 1'b0, 3, 1'b0, 2, 1'b0, 16'd3};

    for (int i = 0; i < 7; i++) begin
      nb = (i < 6) ? rows[i+1].bank : '0;
      if (!rows[i].chained) start_frame(rows[i].bank);
      run_frame($sformatf("row%0d", i), rows[i].bank, rows[i].seq, rows[i].chk, rows[i].stall,
                rows[i].n_mid, rows[i].pulse_chk, nb, rows[i].en_low, bc);
      check($sformatf("row%0d_frame_count", i), 32'(frame_count), 32'(i + 1));
      check($sformatf("row%0d_dropped", i), 32'(dropped_snapshots), 32'(rows[i].exp_drop));
      if (rows[i].pulse_chk) begin
        check($sformatf("row%0d_next_valid", i), 32'(bus.tx_valid), 32'd1);
        check($sformatf("row%0d_next_sync0", i), 32'(bus.tx_data), 32'h000000A5);
      end else begin
        check($sformatf("row%0d_idle_valid", i), 32'(bus.tx_valid), 32'd0);
        check($sformatf("row%0d_idle_busy", i), 32'(busy), 32'd0);
      end
      if (i == 0) check("row0_busy_cycles", 32'(bc), 32'(FL));
    end

    // Idle with enable low clears the statistics and ignores snapshots.
    @(posedge clk); #1;
    check("dis_frame_count", 32'(frame_count), 32'd0);
    check("dis_dropped", 32'(dropped_snapshots), 32'd0);
    start_frame('0);
    repeat (4) @(posedge clk);
    #1;
    check("dis_tx_valid", 32'(bus.tx_valid), 32'd0);
    check("dis_busy", 32'(busy), 32'd0);
    check("dis_dropped_after_pulse", 32'(dropped_snapshots), 32'd0);

    enable = 1'b1;
    start_frame('0);
    run_frame("seqclr", '0, 8'h00, 8'h08, 1'b0, 0, 1'b0, '0, -1, bc);
    check("seqclr_frame_count", 32'(frame_count), 32'd1);

    // Reset in the middle of the payload.
    b = '0; b[0 +: 32] = 32'h11223344;
    start_frame(b);
    for (int c = 0; c < 10; c++) begin
      if (c == 5) snapshot_valid = 1'b1;
      @(posedge clk); #1;
      snapshot_valid = 1'b0;
    end
    check("pre_rst_valid", 32'(bus.tx_valid), 32'd1);
    check("pre_rst_dropped", 32'(dropped_snapshots), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    check("mid_rst_tx_data", 32'(bus.tx_data), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_frame_count", 32'(frame_count), 32'd0);
    check("mid_rst_dropped", 32'(dropped_snapshots), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    start_frame(b);
    run_frame("post_rst0", b, 8'h00, 8'h4C, 1'b0, 0, 1'b0, '0, -1, bc);
    start_frame(b);
    run_frame("post_rst1", b, 8'h01, 8'h4D, 1'b1, 0, 1'b0, '0, -1, bc);
    check("post_rst_frame_count", 32'(frame_count), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
